writeback_unit: RTL



---
 rtl/writeback_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Y86-64 SEQ write-back stage. Accepts one retired instruction
//               through a valid/ready handshake, derives dstE/dstM and puts
//               the E write and then the M write onto the single
//               register-file write port. Invalid icodes raise a sticky error.
//               Optional macro WB_BYPASS_EN forwards the in-flight write onto
//               the decode read data (fwd_val1/fwd_val2).
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 4,
  parameter int RSP_ID = 4,
  parameter int NO_REG = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [REG_W-1:0]  rA,
  input  logic [REG_W-1:0]  rB,
  input  logic              Cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic              wrEn,
  output logic [REG_W-1:0]  registernumber_write,
  output logic [DATA_W-1:0] val_write,
  output logic              wb_done,
  output logic              error,
  input  logic [REG_W-1:0]  rd_reg1,
  input  logic [REG_W-1:0]  rd_reg2,
  input  logic [DATA_W-1:0] rf_val1,
  input  logic [DATA_W-1:0] rf_val2,
  output logic [DATA_W-1:0] fwd_val1,
  output logic [DATA_W-1:0] fwd_val2
);

  localparam logic [REG_W-1:0] C_NO_REG = REG_W'(NO_REG);
  localparam logic [REG_W-1:0] C_RSP    = REG_W'(RSP_ID);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR_E = 2'd1,
    ST_WR_M = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                wr_en_q, wr_en_d;
  logic [REG_W-1:0]    reg_wr_q, reg_wr_d;
  logic [DATA_W-1:0]   val_wr_q, val_wr_d;
  logic                wb_done_q, wb_done_d;
  logic                error_q, error_d;
  logic [REG_W-1:0]    dst_m_q, dst_m_d;
  logic [DATA_W-1:0]   val_m_q, val_m_d;

  logic [REG_W-1:0]    w_dst_e;
  logic [REG_W-1:0]    w_dst_m;
  logic                w_bad;
  logic                w_accept;

  // ifun only matters to execute; the cmov outcome already arrives in Cnd.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  assign in_ready = (state_q == ST_IDLE) && !error_q;
  assign w_accept = in_valid && in_ready;

  // Destination decode of the instruction presented on the input side.
  always_comb begin
    w_dst_e = C_NO_REG;
    w_dst_m = C_NO_REG;
    w_bad   = 1'b0;
    case (icode)
      4'h2:                w_dst_e = Cnd ? rB : C_NO_REG;
      4'h3, 4'h6:          w_dst_e = rB;
      4'h8, 4'h9, 4'hA:    w_dst_e = C_RSP;
      4'hB: begin
        w_dst_e = C_RSP;
        w_dst_m = rA;
      end
      4'h5:                w_dst_m = rA;
      4'hC, 4'hD, 4'hE, 4'hF: w_bad = 1'b1;
      default: ;
    endcase
  end

  // Next state plus the registered outputs belonging to the state being entered.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    reg_wr_d  = C_NO_REG;
    val_wr_d  = '0;
    wb_done_d = 1'b0;
    error_d   = error_q;
    dst_m_d   = dst_m_q;
    val_m_d   = val_m_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_bad) begin
            error_d = 1'b1;
          end else begin
            dst_m_d = w_dst_m;
            val_m_d = valM;
            if (w_dst_e != C_NO_REG) begin
              state_d  = ST_WR_E;
              wr_en_d  = 1'b1;
              reg_wr_d = w_dst_e;
              val_wr_d = valE;
            end else if (w_dst_m != C_NO_REG) begin
              state_d  = ST_WR_M;
              wr_en_d  = 1'b1;
              reg_wr_d = w_dst_m;
              val_wr_d = valM;
            end else begin
              state_d   = ST_DONE;
              wb_done_d = 1'b1;
            end
          end
        end
      end
      ST_WR_E: begin
        if (dst_m_q != C_NO_REG) begin
          state_d  = ST_WR_M;
          wr_en_d  = 1'b1;
          reg_wr_d = dst_m_q;
          val_wr_d = val_m_q;
        end else begin
          state_d   = ST_DONE;
          wb_done_d = 1'b1;
        end
      end
      ST_WR_M: begin
        state_d   = ST_DONE;
        wb_done_d = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      reg_wr_q  <= C_NO_REG;
      val_wr_q  <= '0;
      wb_done_q <= 1'b0;
      error_q   <= 1'b0;
      dst_m_q   <= C_NO_REG;
      val_m_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      reg_wr_q  <= reg_wr_d;
      val_wr_q  <= val_wr_d;
      wb_done_q <= wb_done_d;
      error_q   <= error_d;
      dst_m_q   <= dst_m_d;
      val_m_q   <= val_m_d;
    end
  end

  assign wrEn                 = wr_en_q;
  assign registernumber_write = reg_wr_q;
  assign val_write            = val_wr_q;
  assign wb_done              = wb_done_q;
  assign error                = error_q;

`ifdef WB_BYPASS_EN
  // Same-cycle forward of the value currently being written.
  always_comb begin
    fwd_val1 = rf_val1;
    fwd_val2 = rf_val2;
    if (wr_en_q && (reg_wr_q == rd_reg1) && (rd_reg1 != C_NO_REG)) fwd_val1 = val_wr_q;
    if (wr_en_q && (reg_wr_q == rd_reg2) && (rd_reg2 != C_NO_REG)) fwd_val2 = val_wr_q;
  end
`else
  // Without bypass the register-file read data passes straight through.
  logic unused_rd;
  assign unused_rd = ^{rd_reg1, rd_reg2};
  assign fwd_val1  = rf_val1;
  assign fwd_val2  = rf_val2;
`endif

endmodule
`default_nettype wire
